// File: rtl/hilo_pkg.sv
// Shared encodings and constants for the HI/LO multiply/divide unit.
package hilo_pkg;

  localparam int          DIV_STEPS = 32;
  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_e;

  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/hilo_unit_div_step.sv
// One radix-2 restoring division step on a {rem,quot} shift register.
module div_step (
  input  logic [63:0] rq,
  input  logic [31:0] divisor,
  output logic [63:0] rq_next
);

  logic [32:0] shifted_rem;
  logic        ge;

  // The shifted remainder can exceed 32 bits; the subtraction result never does.
  always_comb begin
    shifted_rem = rq[63:31];
    ge          = shifted_rem >= {1'b0, divisor};
    if (ge) begin
      rq_next = {shifted_rem[31:0] - divisor, rq[30:0], 1'b1};
    end else begin
      rq_next = {shifted_rem[31:0], rq[30:0], 1'b0};
    end
  end

endmodule

// File: rtl/hilo_unit.sv
// Multicycle HI/LO unit: MULT/MULTU/DIV/DIVU/MTHI/MTLO, owns architectural HI and LO.
module hilo_unit
  import hilo_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DATA_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic              flush,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  // Handshake: start is accepted only when busy=0 and flush=0; while busy=1 it is
  // ignored and the issuer must stall. done pulses once when a MUL/DIV commits.

  state_e      state;
  logic [4:0]  count;
  logic [4:0]  step;
  logic [63:0] prod_q;
  logic [63:0] rq_q;
  logic [31:0] divisor_q;
  logic [31:0] dividend_q;
  logic        q_neg_q;
  logic        r_neg_q;
  logic        div0_q;

  logic [63:0] mul_a;
  logic [63:0] mul_b;
  logic [63:0] product;
  logic        is_signed_div;
  logic        rs_neg;
  logic        rt_neg;
  logic [63:0] rq_next;
  logic [31:0] quot;
  logic [31:0] rem;

  always_comb begin
    mul_a = {32'd0, rs_data};
    mul_b = {32'd0, rt_data};
    if (op == OP_MULT) begin
      mul_a = {{32{rs_data[31]}}, rs_data};
      mul_b = {{32{rt_data[31]}}, rt_data};
    end
    // Low 64 bits of the sign-extended product equal the signed 64-bit product.
    product       = mul_a * mul_b;
    is_signed_div = (op == OP_DIV);
    rs_neg        = is_signed_div && rs_data[31];
    rt_neg        = is_signed_div && rt_data[31];
    quot          = rq_q[31:0];
    rem           = rq_q[63:32];
  end

  div_step u_div_step (
    .rq      (rq_q),
    .divisor (divisor_q),
    .rq_next (rq_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      hi         <= '0;
      lo         <= '0;
      count      <= '0;
      step       <= '0;
      prod_q     <= '0;
      rq_q       <= '0;
      divisor_q  <= '0;
      dividend_q <= '0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      div0_q     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !flush) begin
            case (op)
              OP_MTHI: hi <= rs_data;
              OP_MTLO: lo <= rs_data;
              OP_MULT, OP_MULTU: begin
                prod_q <= product;
                count  <= 5'(MULT_CYCLES - 1);
                busy   <= 1'b1;
                state  <= S_MUL;
              end
              OP_DIV, OP_DIVU: begin
                rq_q       <= {32'd0, rs_neg ? abs32(rs_data) : rs_data};
                divisor_q  <= rt_neg ? abs32(rt_data) : rt_data;
                dividend_q <= rs_data;
                q_neg_q    <= rs_neg ^ rt_neg;
                r_neg_q    <= rs_neg;
                div0_q     <= (rt_data == 32'd0);
                step       <= '0;
                busy       <= 1'b1;
                state      <= S_DIV;
              end
              default: ;
            endcase
          end
        end
        S_MUL: begin
          if (flush) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else if (count == 5'd0) begin
            {hi, lo} <= prod_q;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= S_IDLE;
          end else begin
            count <= count - 5'd1;
          end
        end
        S_DIV: begin
          if (flush) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            rq_q <= rq_next;
            step <= step + 5'd1;
            if (step == 5'(DIV_STEPS - 1)) begin
              state <= S_FIX;
            end
          end
        end
        S_FIX: begin
          if (!flush) begin
            // Divide by zero reports the raw dividend in HI, with no sign fix-up.
            if (div0_q) begin
              lo <= DIV0_QUOT;
              hi <= dividend_q;
            end else begin
              lo <= q_neg_q ? (32'd0 - quot) : quot;
              hi <= r_neg_q ? (32'd0 - rem) : rem;
            end
            done <= 1'b1;
          end
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_unit.sv
// Randomized and directed checks of hilo_unit against an arithmetic reference model.
module tb_hilo_unit;
  import hilo_pkg::*;

  localparam int MULT_CYCLES = 5;
  localparam int DIV_LAT     = 33;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] rs_data = '0;
  logic [31:0] rt_data = '0;
  logic        flush = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  logic [63:0] exp_q[$];
  logic [31:0] hi_m = '0;
  logic [31:0] lo_m = '0;
  int          n_checks = 0;
  int          n_fail = 0;

  hilo_unit #(.MULT_CYCLES(MULT_CYCLES), .DATA_W(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .flush   (flush),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Reference: {hi,lo} after op, from MIPS arithmetic rules.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] h,
                                        input logic [31:0] l);
    longint          sa, sb, q, r;
    longint unsigned ua, ub;
    logic [63:0]     res;
    res = {h, l};
    case (o)
      OP_MULT: begin
        sa = $signed(a); sb = $signed(b);
        res = 64'(sa * sb);
      end
      OP_MULTU: begin
        ua = {32'd0, a}; ub = {32'd0, b};
        res = 64'(ua * ub);
      end
      OP_DIV: begin
        if (b == 0) res = {a, 32'hFFFF_FFFF};
        else begin
          sa = $signed(a); sb = $signed(b);
          q = sa / sb; r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      OP_DIVU: begin
        if (b == 0) res = {a, 32'hFFFF_FFFF};
        else res = {a % b, a / b};
      end
      OP_MTHI: res = {a, l};
      OP_MTLO: res = {h, a};
      default: res = {h, l};
    endcase
    return res;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit spur);
    logic [63:0] e;
    int          cyc;
    int          lat;
    e = model(o, a, b, hi_m, lo_m);
    start = 1'b1; op = o; rs_data = a; rt_data = b;
    tick();
    start = 1'b0;
    if (o inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU}) begin
      exp_q.push_back(e);
      lat = (o inside {OP_MULT, OP_MULTU}) ? MULT_CYCLES : DIV_LAT;
      cyc = 0;
      while (busy === 1'b1 && cyc < 200) begin
        cyc++;
        if (spur && cyc == 2) begin
          start = 1'b1; op = 3'($urandom_range(1, 6));
          rs_data = $urandom; rt_data = $urandom;
        end else begin
          start = 1'b0;
        end
        tick();
      end
      start = 1'b0;
      check("latency", 64'(cyc), 64'(lat));
      check("done_pulse", {63'd0, done}, 64'd1);
      check("result", {hi, lo}, exp_q.pop_front());
      tick();
      check("done_clear", {63'd0, done}, 64'd0);
    end else begin
      check("mt_busy", {63'd0, busy}, 64'd0);
      check("mt_done", {63'd0, done}, 64'd0);
      check("mt_result", {hi, lo}, e);
    end
    {hi_m, lo_m} = e;
  endtask

  initial begin
    logic [2:0]  o;
    logic [31:0] a, b;

    // Reset
    repeat (2) @(posedge clk);
    #1;
    check("reset_hilo", {hi, lo}, 64'd0);
    check("reset_busy", {62'd0, busy, done}, 64'd0);
    reset = 1'b0;

    // MTHI / MTLO
    run_op(OP_MTHI, 32'h1234_5678, 32'd0, 1'b0);
    run_op(OP_MTLO, 32'hDEAD_BEEF, 32'd0, 1'b0);
    check("mt_const", {hi, lo}, 64'h1234_5678_DEAD_BEEF);

    // Multiply
    run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0);
    check("mult_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op(OP_MULTU, 32'hFFFF_FFFD, 32'd7, 1'b0);
    check("multu_const", {hi, lo}, 64'h0000_0006_FFFF_FFEB);

    // Divide, including divide-by-zero and the overflow case
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check("div_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(OP_DIVU, 32'd100, 32'd7, 1'b0);
    check("divu_const", {hi, lo}, {32'd2, 32'd14});
    run_op(OP_DIVU, 32'd100, 32'd0, 1'b0);
    check("divu0_const", {hi, lo}, {32'd100, 32'hFFFF_FFFF});
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check("div_ovf_const", {hi, lo}, {32'd0, 32'h8000_0000});
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd0, 1'b0);
    check("div0_const", {hi, lo}, {32'hFFFF_FFF9, 32'hFFFF_FFFF});

    // Flush mid-divide, with an ignored start on busy cycle 3
    run_op(OP_MTHI, 32'hAAAA_0000, 32'd0, 1'b0);
    run_op(OP_MTLO, 32'h0000_5555, 32'd0, 1'b0);
    start = 1'b1; op = OP_DIV; rs_data = 32'd1000; rt_data = 32'd3;
    tick();
    start = 1'b0;
    check("flush_busy1", {63'd0, busy}, 64'd1);
    repeat (2) tick();
    start = 1'b1; op = OP_MTHI; rs_data = 32'h0000_DEAD;
    tick();
    start = 1'b0;
    check("busy_start_ignored", {hi, lo}, 64'hAAAA_0000_0000_5555);
    repeat (6) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_busy", {63'd0, busy}, 64'd0);
    check("flush_done", {63'd0, done}, 64'd0);
    check("flush_hilo", {hi, lo}, 64'hAAAA_0000_0000_5555);
    repeat (40) begin
      tick();
      if (done !== 1'b0) check("flush_late_done", {63'd0, done}, 64'd0);
    end
    check("flush_hilo_after", {hi, lo}, 64'hAAAA_0000_0000_5555);

    // Reset during a multiply
    start = 1'b1; op = OP_MULT; rs_data = 32'd3; rt_data = 32'd5;
    tick();
    start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_mid_hilo", {hi, lo}, 64'd0);
    check("rst_mid_busy", {62'd0, busy, done}, 64'd0);
    hi_m = '0; lo_m = '0;
    repeat (8) tick();
    check("rst_mid_no_commit", {hi, lo}, 64'd0);

    // flush + start together from IDLE
    flush = 1'b1; start = 1'b1; op = OP_MULT; rs_data = 32'd9; rt_data = 32'd9;
    tick();
    start = 1'b0; flush = 1'b0;
    check("flush_start_busy", {63'd0, busy}, 64'd0);
    flush = 1'b1; start = 1'b1; op = OP_MTLO; rs_data = 32'h0BAD_F00D;
    tick();
    start = 1'b0; flush = 1'b0;
    repeat (MULT_CYCLES + 2) tick();
    check("flush_start_hilo", {hi, lo}, 64'd0);
    check("flush_start_done", {63'd0, done}, 64'd0);

    // Randomized ops against the model, with occasional starts while busy
    for (int i = 0; i < 60; i++) begin
      o = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: begin a = $urandom; b = $urandom; end
        1: begin a = 32'($urandom_range(0, 300)); b = 32'($urandom_range(1, 20)); end
        2: begin a = $urandom; b = 32'd0; end
        default: begin
          a = ($urandom_range(0, 1) == 0) ? 32'h8000_0000 : 32'hFFFF_FFFF;
          b = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : 32'h8000_0000;
        end
      endcase
      run_op(o, a, b, $urandom_range(0, 3) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
